// File: rtl/accumulator_datapath_if.sv
// rtl/accumulator_datapath_if.sv - controller-to-datapath strobes, sample word and frame results
interface accumulator_datapath_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 9,
    parameter int CNT_W = 3
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [ACC_W-1:0] sum_out;
    logic [CNT_W-1:0] count_out;
    logic [ACC_W-1:0] result;
    logic             done;
    logic             overflow;

    modport master (
        output clear, load, data_in,
        input  sum_out, count_out, result, done, overflow
    );

    modport slave (
        input  clear, load, data_in,
        output sum_out, count_out, result, done, overflow
    );
endinterface

// File: rtl/accumulator_datapath.sv
// rtl/accumulator_datapath.sv - frame accumulator: sums N_SAMPLES loads, publishes result with done pulse
// SATURATE_EN: when defined, an overflowing add clamps the sum to all-ones instead of wrapping.
module accumulator_datapath #(
    parameter int WIDTH     = 8,
    parameter int ACC_W     = 9,
    parameter int N_SAMPLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    accumulator_datapath_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic [ACC_W-1:0] result_q;
    logic             done_q;
    logic             overflow_q;

    logic [ACC_W-1:0] add_base;
    logic [ACC_W:0]   add_full;
    logic             add_carry;
    logic [ACC_W-1:0] add_sum;
    logic [CNT_W-1:0] next_count;
    logic             frame_end;

    // Only RUN continues a frame; IDLE and DONE both start a fresh one from zero.
    always_comb begin
        add_base   = (state == RUN) ? sum_q : '0;
        add_full   = {1'b0, add_base} + {{(ACC_W + 1 - WIDTH){1'b0}}, bus.data_in};
        add_carry  = add_full[ACC_W];
        add_sum    = add_full[ACC_W-1:0];
`ifdef SATURATE_EN
        if (add_carry) begin
            add_sum = '1;
        end
`endif
        next_count = (state == RUN) ? count_q + 1'b1 : CNT_W'(1);
        frame_end  = (next_count == CNT_W'(N_SAMPLES));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            sum_q      <= '0;
            count_q    <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.clear) begin
            state      <= IDLE;
            sum_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                sum_q   <= add_sum;
                count_q <= next_count;
                if (add_carry) begin
                    overflow_q <= 1'b1;
                end
                if (frame_end) begin
                    result_q <= add_sum;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end else begin
                    state    <= RUN;
                end
            end else if (state != RUN) begin
                state   <= IDLE;
                sum_q   <= '0;
                count_q <= '0;
            end
        end
    end

    assign bus.sum_out   = sum_q;
    assign bus.count_out = count_q;
    assign bus.result    = result_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_accumulator_datapath.sv
// tb/tb_accumulator_datapath.sv - directed self-checking bench for accumulator_datapath
module tb_accumulator_datapath;
    localparam int WIDTH     = 8;
    localparam int ACC_W     = 9;
    localparam int N_SAMPLES = 4;
    localparam int CNT_W     = 3;

`ifdef SATURATE_EN
    localparam int OVF_SUM    = 511;
    localparam int OVF_RESULT = 511;
`else
    localparam int OVF_SUM    = 88;
    localparam int OVF_RESULT = 89;
`endif

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    accumulator_datapath_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    accumulator_datapath #(
        .WIDTH(WIDTH), .ACC_W(ACC_W), .N_SAMPLES(N_SAMPLES), .CNT_W(CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic ld, input logic clr, input int data);
        bus.load    = ld;
        bus.clear   = clr;
        bus.data_in = WIDTH'(data);
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input int sum, input int cnt,
                              input int res, input int dn, input int ovf);
        check({tag, ".sum"},      int'(bus.sum_out),   sum);
        check({tag, ".count"},    int'(bus.count_out), cnt);
        check({tag, ".result"},   int'(bus.result),    res);
        check({tag, ".done"},     int'(bus.done),      dn);
        check({tag, ".overflow"}, int'(bus.overflow),  ovf);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b0;
        bus.clear   = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = '0;

        // reset, then controller holding clear
        step(1'b1, 1'b0, 99);
        step(1'b1, 1'b0, 99);
        expect_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 55);
        expect_out("held_clear", 0, 0, 0, 0, 0);

        // back-to-back frame
        step(1'b1, 1'b0, 10);  expect_out("f1_l1", 10, 1, 0, 0, 0);
        step(1'b1, 1'b0, 20);  expect_out("f1_l2", 30, 2, 0, 0, 0);
        step(1'b1, 1'b0, 30);  expect_out("f1_l3", 60, 3, 0, 0, 0);
        step(1'b1, 1'b0, 40);  expect_out("f1_l4", 100, 4, 100, 1, 0);
        step(1'b0, 1'b0, 0);   expect_out("f1_idle", 0, 0, 100, 0, 0);

        // gap in the middle of a frame
        step(1'b1, 1'b0, 10);  expect_out("f2_l1", 10, 1, 100, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 77);
            expect_out("f2_gap", 10, 1, 100, 0, 0);
        end
        step(1'b1, 1'b0, 20);  expect_out("f2_l2", 30, 2, 100, 0, 0);
        step(1'b1, 1'b0, 30);  expect_out("f2_l3", 60, 3, 100, 0, 0);
        step(1'b1, 1'b0, 40);  expect_out("f2_l4", 100, 4, 100, 1, 0);
        step(1'b0, 1'b0, 0);   expect_out("f2_idle", 0, 0, 100, 0, 0);

        // overflow, persisting into the next frame
        step(1'b1, 1'b0, 200); expect_out("f3_l1", 200, 1, 100, 0, 0);
        step(1'b1, 1'b0, 200); expect_out("f3_l2", 400, 2, 100, 0, 0);
        step(1'b1, 1'b0, 200); expect_out("f3_l3", OVF_SUM, 3, 100, 0, 1);
        step(1'b1, 1'b0, 1);   expect_out("f3_l4", OVF_RESULT, 4, OVF_RESULT, 1, 1);
        step(1'b1, 1'b0, 3);   expect_out("f4_l1", 3, 1, OVF_RESULT, 0, 1);
        step(1'b1, 1'b1, 9);   expect_out("f4_clear", 0, 0, OVF_RESULT, 0, 0);

        // clear wins over a simultaneous load
        step(1'b1, 1'b0, 5);   expect_out("f5_l1", 5, 1, OVF_RESULT, 0, 0);
        step(1'b1, 1'b0, 5);   expect_out("f5_l2", 10, 2, OVF_RESULT, 0, 0);
        step(1'b1, 1'b1, 5);   expect_out("f5_clear", 0, 0, OVF_RESULT, 0, 0);
        step(1'b0, 1'b0, 0);   expect_out("f5_idle", 0, 0, OVF_RESULT, 0, 0);

        // load during DONE starts the next frame without an IDLE cycle
        step(1'b1, 1'b0, 1);   expect_out("f6_l1", 1, 1, OVF_RESULT, 0, 0);
        step(1'b1, 1'b0, 2);   expect_out("f6_l2", 3, 2, OVF_RESULT, 0, 0);
        step(1'b1, 1'b0, 3);   expect_out("f6_l3", 6, 3, OVF_RESULT, 0, 0);
        step(1'b1, 1'b0, 4);   expect_out("f6_l4", 10, 4, 10, 1, 0);
        step(1'b1, 1'b0, 7);   expect_out("f7_l1", 7, 1, 10, 0, 0);
        step(1'b1, 1'b0, 8);   expect_out("f7_l2", 15, 2, 10, 0, 0);

        // reset mid-frame
        reset = 1'b0;
        step(1'b1, 1'b0, 9);   expect_out("mid_reset", 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(1'b0, 1'b0, 0);   expect_out("post_reset", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
